muldiv_unit: RTL and testbench
==============================

MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have parameter: XLEN, 32, operand/result width.
REQ-002 SHALL have port: clk  input  1  rising-edge clock; the only clock.
REQ-003 SHALL have port: rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port: start  input  1  request; sampled only while busy=0.
REQ-005 SHALL have port: op  input  3  = control-unit aluc[5:3]; 000 mul, 010 mulh, 100 mulhsu, 110 mulhu, 001 div, 011 divu, 101 rem, 111 remu.
REQ-006 SHALL have port: a  input  XLEN  rs1 operand (multiplicand/dividend).
REQ-007 SHALL have port: b  input  XLEN  rs2 operand (multiplier/divisor).
REQ-008 SHALL have port: busy  output  1  operation in flight; pipeline stalls on it.
REQ-009 SHALL have port: done  output  1  one-cycle pulse; result valid.
REQ-010 SHALL have port: result  output  XLEN  registered result.

Function
REQ-011 SHALL use states IDLE, MUL, DIV, DONE; busy=1 in MUL and DIV only; done=1 in DONE only.
REQ-012 SHALL accept start only in IDLE or DONE; start in MUL/DIV is ignored, with no queuing.
REQ-013 SHALL capture op, a and b at the accepting edge; later input changes have no effect.
REQ-014 SHALL route an accepted op[0]=0 to MUL, then to DONE on the next edge, with done high in the 2nd cycle after the start cycle.
REQ-015 SHALL form the mul product as a 2*XLEN product of operands extended per op (mulh both signed; mulhsu a signed, b unsigned; mulhu both unsigned); mul returns the low XLEN bits and the others the high XLEN bits.
REQ-016 SHALL route an accepted op[0]=1 to DIV for an unsigned restoring divide of magnitudes, one quotient bit per edge, 32 iterations, with sign fix-up applied when entering DONE; done is high in the 33rd cycle after the start cycle.
REQ-017 SHALL give signed division (div/rem) a quotient that truncates toward zero and a remainder carrying the dividend's sign.
REQ-018 SHALL fast-path divide-by-zero (b=0) through MUL-length latency (done in 2nd cycle): quotient 0xFFFFFFFF, remainder = a.
REQ-019 SHALL fast-path signed overflow (div/rem, a=0x80000000, b=0xFFFFFFFF) with latency 2: quotient 0x80000000, remainder 0.
REQ-020 SHALL hold result stable from done until the next accepted start's done.
REQ-021 SHALL return from DONE to IDLE without start, or enter MUL/DIV on start (back-to-back allowed, no bubble).

Reset
REQ-022 SHALL, on rst=1 at a clock edge, go to IDLE with busy=0, done=0, result=0 and iteration counter=0, aborting any operation.
REQ-023 SHALL give rst priority over a simultaneous start; the start is dropped.
REQ-024 SHALL have no asynchronous reset paths.

Structure
REQ-025 SHALL take op encodings (MD_MUL...MD_REMU) and the state enum from the shared package riscv_pkg, which is shared with control_unit.
REQ-026 SHALL have one sub-module, muldiv_div_core: a remainder/quotient shift register plus 6-bit counter, iterating under a step enable and flagging the last iteration.
REQ-027 SHALL keep multiply as a single registered 33x33 signed product inside muldiv_unit.

Verification
REQ-028 SHALL cover: mul a=7, b=0xFFFFFFFD -> result 0xFFFFFFEB, done in 2nd cycle, busy high 1 cycle.
REQ-029 SHALL cover: mulhu a=b=0xFFFFFFFF -> 0xFFFFFFFE; mulhsu same operands -> 0xFFFFFFFF; mulh same operands -> 0x00000000.
REQ-030 SHALL cover: div a=0xFFFFFFEC(-20), b=3 -> 0xFFFFFFFA; rem -> 0xFFFFFFFE; remu a=100, b=7 -> 2; done in 33rd cycle, start during busy ignored.
REQ-031 SHALL cover: divu a=100, b=0 -> 0xFFFFFFFF and rem a=100, b=0 -> 100, both done in 2nd cycle; div 0x80000000/0xFFFFFFFF -> 0x80000000, rem -> 0.
REQ-032 SHALL cover: rst asserted at 10th DIV cycle -> next cycle busy=0, done=0, result=0; subsequent mul 6*7 -> 42.
REQ-033 SHALL cover: start asserted in DONE cycle of mul 2*3 with divu 9/2 -> done pulses: result 6, then 33 cycles later 4.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared encodings for the M-extension datapath: muldiv op codes (aluc[5:3])
// and the muldiv sequencer states, also consumed by control_unit.
package riscv_pkg;

  localparam logic [2:0] MD_MUL    = 3'b000;
  localparam logic [2:0] MD_MULH   = 3'b010;
  localparam logic [2:0] MD_MULHSU = 3'b100;
  localparam logic [2:0] MD_MULHU  = 3'b110;
  localparam logic [2:0] MD_DIV    = 3'b001;
  localparam logic [2:0] MD_DIVU   = 3'b011;
  localparam logic [2:0] MD_REM    = 3'b101;
  localparam logic [2:0] MD_REMU   = 3'b111;

  localparam int MD_CNT_W = 6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } md_state_e;

  function automatic logic md_signed_div(input logic [2:0] op);
    return (op == MD_DIV) || (op == MD_REM);
  endfunction

  function automatic logic md_is_rem(input logic [2:0] op);
    return (op == MD_REM) || (op == MD_REMU);
  endfunction

  // mulh and mulhsu treat rs1 as signed; only mulh treats rs2 as signed
  function automatic logic md_a_signed(input logic [2:0] op);
    return (op == MD_MULH) || (op == MD_MULHSU);
  endfunction

  function automatic logic md_b_signed(input logic [2:0] op);
    return op == MD_MULH;
  endfunction

  function automatic logic md_mul_high(input logic [2:0] op);
    return (op == MD_MULH) || (op == MD_MULHSU) || (op == MD_MULHU);
  endfunction

endpackage

// File: rtl/muldiv_div_core.sv
// Unsigned restoring divider: one quotient bit per step, with the next
// quotient/remainder exposed so the caller can fix up signs on the last step.
module muldiv_div_core
  import riscv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_load,
  input  logic            i_step,
  input  logic [XLEN-1:0] i_dividend,
  input  logic [XLEN-1:0] i_divisor,
  output logic [XLEN-1:0] o_quotNext,
  output logic [XLEN-1:0] o_remNext,
  output logic            o_last
);

  localparam logic [MD_CNT_W-1:0] LAST_CNT = MD_CNT_W'(XLEN - 1);
  localparam logic [MD_CNT_W-1:0] CNT_ONE  = MD_CNT_W'(1);

  logic [XLEN-1:0]     r_rem;
  logic [XLEN-1:0]     r_quot;
  logic [XLEN-1:0]     r_divisor;
  logic [MD_CNT_W-1:0] r_count;

  logic [XLEN:0] w_shifted;
  logic [XLEN:0] w_trial;
  logic          w_fits;

  // The dividend shifts out of the quotient register MSB-first into the remainder
  assign w_shifted  = {r_rem, r_quot[XLEN-1]};
  assign w_trial    = w_shifted - {1'b0, r_divisor};
  assign w_fits     = ~w_trial[XLEN];
  assign o_remNext  = w_fits ? w_trial[XLEN-1:0] : w_shifted[XLEN-1:0];
  assign o_quotNext = {r_quot[XLEN-2:0], w_fits};
  assign o_last     = (r_count == LAST_CNT);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rem     <= '0;
      r_quot    <= '0;
      r_divisor <= '0;
      r_count   <= '0;
    end else if (i_load) begin
      r_rem     <= '0;
      r_quot    <= i_dividend;
      r_divisor <= i_divisor;
      r_count   <= '0;
    end else if (i_step) begin
      r_rem     <= o_remNext;
      r_quot    <= o_quotNext;
      r_count   <= r_count + CNT_ONE;
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// RV32M multiply/divide unit: two-cycle multiply and div fast paths,
// 33-cycle iterative divide, single-cycle done pulse with a held result.
module muldiv_unit
  import riscv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  md_state_e       r_state;
  logic            r_busy;
  logic            r_done;
  logic [XLEN-1:0] r_result;
  logic [2:0]      r_op;
  logic [XLEN-1:0] r_a;
  logic [XLEN-1:0] r_b;

  logic            w_accept;
  logic            w_bZero;
  logic            w_overflow;
  logic            w_toDiv;
  logic            w_aNeg;
  logic            w_bNeg;
  logic [XLEN-1:0] w_aMag;
  logic [XLEN-1:0] w_bMag;

  logic [XLEN:0]       w_aExt;
  logic [XLEN:0]       w_bExt;
  logic signed [2*XLEN-1:0] w_aWide;
  logic signed [2*XLEN-1:0] w_bWide;
  logic signed [2*XLEN-1:0] w_product;
  logic [XLEN-1:0]     w_mulResult;
  logic [XLEN-1:0]     w_fastResult;
  logic [XLEN-1:0]     w_shortResult;

  logic [XLEN-1:0] w_quotNext;
  logic [XLEN-1:0] w_remNext;
  logic            w_last;
  logic            w_quotNeg;
  logic            w_remNeg;
  logic [XLEN-1:0] w_divResult;

  assign busy   = r_busy;
  assign done   = r_done;
  assign result = r_result;

  assign w_accept   = ((r_state == IDLE) || (r_state == DONE)) && start;
  assign w_bZero    = (b == '0);
  assign w_overflow = md_signed_div(op) && (a == INT_MIN) && (b == '1);
  // Divide-by-zero and signed overflow skip the iterative divider entirely
  assign w_toDiv    = op[0] && !w_bZero && !w_overflow;

  assign w_aNeg = md_signed_div(op) && a[XLEN-1];
  assign w_bNeg = md_signed_div(op) && b[XLEN-1];
  assign w_aMag = w_aNeg ? -a : a;
  assign w_bMag = w_bNeg ? -b : b;

  muldiv_div_core #(
    .XLEN(XLEN)
  ) u_divCore (
    .clk       (clk),
    .rst       (rst),
    .i_load    (w_accept && w_toDiv),
    .i_step    (r_state == DIV),
    .i_dividend(w_aMag),
    .i_divisor (w_bMag),
    .o_quotNext(w_quotNext),
    .o_remNext (w_remNext),
    .o_last    (w_last)
  );

  // 33x33 signed product, carried at 2*XLEN since the top two bits never matter
  assign w_aExt    = {md_a_signed(r_op) & r_a[XLEN-1], r_a};
  assign w_bExt    = {md_b_signed(r_op) & r_b[XLEN-1], r_b};
  assign w_aWide   = {{(XLEN-1){w_aExt[XLEN]}}, w_aExt};
  assign w_bWide   = {{(XLEN-1){w_bExt[XLEN]}}, w_bExt};
  assign w_product = w_aWide * w_bWide;
  assign w_mulResult = md_mul_high(r_op) ? w_product[2*XLEN-1:XLEN]
                                         : w_product[XLEN-1:0];

  always_comb begin
    w_fastResult = '0;
    if (r_b == '0) begin
      w_fastResult = md_is_rem(r_op) ? r_a : '1;
    end else begin
      w_fastResult = md_is_rem(r_op) ? '0 : INT_MIN;
    end
  end

  assign w_shortResult = r_op[0] ? w_fastResult : w_mulResult;

  assign w_quotNeg   = md_signed_div(r_op) && (r_a[XLEN-1] ^ r_b[XLEN-1]);
  assign w_remNeg    = md_signed_div(r_op) && r_a[XLEN-1];
  assign w_divResult = md_is_rem(r_op) ? (w_remNeg  ? -w_remNext  : w_remNext)
                                       : (w_quotNeg ? -w_quotNext : w_quotNext);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_result <= '0;
      r_op     <= '0;
      r_a      <= '0;
      r_b      <= '0;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          r_done <= 1'b0;
          if (start) begin
            r_op   <= op;
            r_a    <= a;
            r_b    <= b;
            r_busy <= 1'b1;
            r_state <= w_toDiv ? DIV : MUL;
          end else begin
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end
        end
        MUL: begin
          r_result <= w_shortResult;
          r_busy   <= 1'b0;
          r_done   <= 1'b1;
          r_state  <= DONE;
        end
        DIV: begin
          if (w_last) begin
            r_result <= w_divResult;
            r_busy   <= 1'b0;
            r_done   <= 1'b1;
            r_state  <= DONE;
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: a vector table for results and latencies,
// plus hand sequences for busy-start, mid-divide reset and back-to-back issue.
module tb_muldiv_unit;
  import riscv_pkg::*;

  localparam int XLEN  = 32;
  localparam int BOUND = 60;

  typedef struct {
    string       name;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] expResult;
    int          expLatency;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int   checks = 0;
  int   errors = 0;
  vec_t vecs[$];

  muldiv_unit #(.XLEN(XLEN)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .result(result)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, want %h", name, actual, expected);
    end
  endtask

  task automatic addVec(input string name, input logic [2:0] vop, input logic [31:0] va,
                        input logic [31:0] vb, input logic [31:0] res, input int lat);
    vec_t v;
    v.name = name; v.op = vop; v.a = va; v.b = vb; v.expResult = res; v.expLatency = lat;
    vecs.push_back(v);
  endtask

  // Called on the negedge of cycle 1 (start already dropped); returns on the done negedge
  task automatic waitDone(input string name, input int expLatency, input logic [31:0] expResult);
    int cycles = 1;
    int busyCycles = 0;
    while (done !== 1'b1 && cycles < BOUND) begin
      if (busy === 1'b1) busyCycles++;
      @(negedge clk);
      cycles++;
    end
    checkOutput({name, " latency"}, 32'(cycles), 32'(expLatency));
    checkOutput({name, " busy cycles"}, 32'(busyCycles), 32'(expLatency - 1));
    checkOutput({name, " busy at done"}, {31'd0, busy}, 32'd0);
    checkOutput({name, " result"}, result, expResult);
  endtask

  task automatic applyStimulus(input vec_t v);
    op = v.op; a = v.a; b = v.b; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    waitDone(v.name, v.expLatency, v.expResult);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int cycles;
    int doneSeen;
    vec_t v;

    addVec("mul 7*-3",        MD_MUL,    32'd7,         32'hFFFFFFFD, 32'hFFFFFFEB, 2);
    addVec("mulhu -1*-1",     MD_MULHU,  32'hFFFFFFFF,  32'hFFFFFFFF, 32'hFFFFFFFE, 2);
    addVec("mulhsu -1*max",   MD_MULHSU, 32'hFFFFFFFF,  32'hFFFFFFFF, 32'hFFFFFFFF, 2);
    addVec("mulh -1*-1",      MD_MULH,   32'hFFFFFFFF,  32'hFFFFFFFF, 32'h00000000, 2);
    addVec("div -20/3",       MD_DIV,    32'hFFFFFFEC,  32'd3,        32'hFFFFFFFA, 33);
    addVec("rem -20%3",       MD_REM,    32'hFFFFFFEC,  32'd3,        32'hFFFFFFFE, 33);
    addVec("remu 100%7",      MD_REMU,   32'd100,       32'd7,        32'd2,        33);
    addVec("divu 100/7",      MD_DIVU,   32'd100,       32'd7,        32'd14,       33);
    addVec("div 7/-2",        MD_DIV,    32'd7,         32'hFFFFFFFE, 32'hFFFFFFFD, 33);
    addVec("rem 7%-2",        MD_REM,    32'd7,         32'hFFFFFFFE, 32'd1,        33);
    addVec("divu 100/0",      MD_DIVU,   32'd100,       32'd0,        32'hFFFFFFFF, 2);
    addVec("rem 100%0",       MD_REM,    32'd100,       32'd0,        32'd100,      2);
    addVec("div ovf",         MD_DIV,    32'h80000000,  32'hFFFFFFFF, 32'h80000000, 2);
    addVec("rem ovf",         MD_REM,    32'h80000000,  32'hFFFFFFFF, 32'd0,        2);

    rst = 1'b1; start = 1'b0; op = MD_MUL; a = '0; b = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    checkOutput("reset busy", {31'd0, busy}, 32'd0);
    checkOutput("reset done", {31'd0, done}, 32'd0);
    checkOutput("reset result", result, 32'd0);

    foreach (vecs[i]) begin
      applyStimulus(vecs[i]);
      @(negedge clk);
      checkOutput({vecs[i].name, " done pulse"}, {31'd0, done}, 32'd0);
      checkOutput({vecs[i].name, " result held"}, result, vecs[i].expResult);
    end

    // start while dividing is dropped, and later operand changes are ignored
    op = MD_DIV; a = 32'hFFFFFFEC; b = 32'd3; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    cycles = 1;
    while (done !== 1'b1 && cycles < BOUND) begin
      if (cycles == 5) begin
        start = 1'b1; op = MD_MUL; a = 32'd2; b = 32'd3;
      end else if (cycles == 6) begin
        start = 1'b0; op = MD_REMU; a = 32'd5; b = 32'd5;
      end
      @(negedge clk);
      cycles++;
    end
    checkOutput("busy-start latency", 32'(cycles), 32'd33);
    checkOutput("busy-start result", result, 32'hFFFFFFFA);
    @(negedge clk);
    checkOutput("busy-start no extra done", {31'd0, done}, 32'd0);

    // reset in the 10th DIV cycle aborts the divide
    op = MD_DIV; a = 32'hFFFFFFEC; b = 32'd3; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    checkOutput("abort busy", {31'd0, busy}, 32'd0);
    checkOutput("abort done", {31'd0, done}, 32'd0);
    checkOutput("abort result", result, 32'd0);
    doneSeen = 0;
    repeat (35) begin
      @(negedge clk);
      if (done === 1'b1) doneSeen++;
    end
    checkOutput("abort no late done", 32'(doneSeen), 32'd0);
    v.name = "mul 6*7"; v.op = MD_MUL; v.a = 32'd6; v.b = 32'd7; v.expResult = 32'd42; v.expLatency = 2;
    applyStimulus(v);
    @(negedge clk);

    // reset wins over a simultaneous start
    rst = 1'b1; start = 1'b1; op = MD_MUL; a = 32'd2; b = 32'd3;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    checkOutput("rst-vs-start busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    checkOutput("rst-vs-start done", {31'd0, done}, 32'd0);
    checkOutput("rst-vs-start result", result, 32'd0);

    // back-to-back: divu issued in the DONE cycle of the mul
    v.name = "b2b mul 2*3"; v.op = MD_MUL; v.a = 32'd2; v.b = 32'd3; v.expResult = 32'd6; v.expLatency = 2;
    applyStimulus(v);
    v.name = "b2b divu 9/2"; v.op = MD_DIVU; v.a = 32'd9; v.b = 32'd2; v.expResult = 32'd4; v.expLatency = 33;
    applyStimulus(v);
    @(negedge clk);
    checkOutput("b2b done pulse", {31'd0, done}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
